serial_adder_seq: RTL and testbench

Bit-serial N-bit adder that drives a single 1-bit full-adder slice, presenting one bit of each operand per clock.
- Accepts two operands and a carry-in over a valid/ready handshake.
- Shifts the operands LSB-first through the slice, with the carry held in a flip-flop between cycles.
- Returns the WIDTH-bit sum, the carry-out and a signed-overflow flag over a second valid/ready handshake.
- Sits between an operand source (register file or test driver) and a result consumer. It is the area-minimal alternative to a ripple-carry array.

---
 rtl/serial_adder_seq.sv | 109 ++++++++++
 tb/tb_serial_adder_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial WIDTH-bit adder around a single full-adder slice
// Operands shift LSB-first through the slice; the carry lives in a flop between cycles.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c;
    logic             cmsb;

    // One full-adder slice; sum_shift is the sum register after this bit lands at the MSB.
    always_comb begin
        s         = a_sr[0] ^ b_sr[0] ^ carry;
        c         = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        cmsb      = carry;
        sum_shift = sum_sr >> 1;
        sum_shift[WIDTH-1] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift;
                    carry  <= c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum       <= sum_shift;
                        cout      <= c;
                        ovf       <= cmsb ^ c;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - random and directed checks of serial_adder_seq at WIDTH=8 and WIDTH=1
// A per-cycle monitor compares both instances against an arithmetic model of the handshake.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    logic       iv8 = 1'b0, ordy8 = 1'b1, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8, ovf8, busy8;
    logic [7:0] sum8;

    logic       iv1 = 1'b0, ordy1 = 1'b1, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, cout1, ovf1, busy1;
    logic [0:0] sum1;

    logic        pend [2] = '{1'b0, 1'b0};
    int          acc_c[2] = '{0, 0};
    logic [33:0] pres [2] = '{34'd0, 34'd0};
    logic [33:0] last [2] = '{34'd0, 34'd0};

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(in_ready8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(ordy8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    serial_adder_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(ordy1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {ovf, cout, sum} from integer arithmetic on unsigned and signed readings.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci);
        longint ua, ub, tot, mask, half, sa, sb, st;
        logic [31:0] sm;
        logic co, of;
        ua   = longint'(av);
        ub   = longint'(bv);
        tot  = ua + ub + longint'(ci);
        mask = (longint'(1) << w) - 1;
        sm   = 32'(tot & mask);
        co   = tot[w];
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        st   = sa + sb + longint'(ci);
        of   = (st >= half) || (st < -half);
        return {of, co, sm};
    endfunction

    task automatic mon(input int id, input int w, input logic iv, input logic ir, input logic ov,
                       input logic ordy, input logic bz, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic [31:0] s, input logic co, input logic of);
        logic ov_exp;
        ov_exp = pend[id] && (cyc - acc_c[id] >= w + 1);
        chk($sformatf("d%0d_in_ready", id), 34'(ir), 34'(!pend[id]));
        chk($sformatf("d%0d_out_valid", id), 34'(ov), 34'(ov_exp));
        chk($sformatf("d%0d_busy", id), 34'(bz), 34'(pend[id] && !ov_exp));
        chk($sformatf("d%0d_result", id), {of, co, s}, ov_exp ? pres[id] : last[id]);
        if (ov_exp && ordy) begin
            last[id] = pres[id];
            pend[id] = 1'b0;
        end else if (!pend[id] && iv) begin
            pend[id]  = 1'b1;
            acc_c[id] = cyc;
            pres[id]  = model(w, av, bv, ci);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs8", {28'd0, in_ready8, out_valid8, busy8, cout8, ovf8, 1'b0},
                {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
            chk("rst_sum8", 34'(sum8), 34'd0);
            chk("rst_outputs1", {27'd0, in_ready1, out_valid1, busy1, cout1, ovf1, sum1, 1'b0},
                {27'd0, 1'b1, 6'd0});
            for (int i = 0; i < 2; i++) begin
                pend[i] = 1'b0;
                last[i] = '0;
            end
        end else begin
            mon(0, 8, iv8, in_ready8, out_valid8, ordy8, busy8, {24'd0, a8}, {24'd0, b8}, cin8,
                {24'd0, sum8}, cout8, ovf8);
            mon(1, 1, iv1, in_ready1, out_valid1, ordy1, busy1, {31'd0, a1}, {31'd0, b1}, cin1,
                {31'd0, sum1}, cout1, ovf1);
        end
    end

    task automatic send(input int id, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        output int acc);
        logic hs;
        int   n;
        hs  = 1'b0;
        n   = 0;
        acc = 0;
        if (id == 0) begin
            iv8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci;
        end else begin
            iv1 = 1'b1; a1 = av[0:0]; b1 = bv[0:0]; cin1 = ci;
        end
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = (id == 0) ? in_ready8 : in_ready1;
            if (hs) acc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("d%0d_accept_timeout", id), 34'(hs), 34'd1);
        if (id == 0) iv8 = 1'b0;
        else iv1 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic [9:0] ex, input string name);
        int acc, n;
        send(0, {24'd0, av}, {24'd0, bv}, ci, acc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid8 && n < 50);
        chk({name, "_done"}, 34'(out_valid8), 34'd1);
        chk({name, "_latency"}, 34'(cyc - acc), 34'd9);
        chk({name, "_result"}, 34'({ovf8, cout8, sum8}), 34'(ex));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, prev, n;
        logic [31:0] ra, rb;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset", {31'd0, in_ready8, out_valid8, busy8}, {31'd0, 3'b100});
        chk("post_reset_sum", 34'({ovf8, cout8, sum8}), 34'd0);

        chk("model_basic", model(8, 32'h5A, 32'h33, 1'b0), {1'b1, 1'b0, 32'h8D});
        chk("model_wrap", model(8, 32'hFF, 32'h01, 1'b0), {1'b0, 1'b1, 32'h00});
        chk("model_cin_ovf", model(8, 32'h7F, 32'h00, 1'b1), {1'b1, 1'b0, 32'h80});
        chk("model_w1", model(1, 32'h1, 32'h1, 1'b1), {1'b0, 1'b1, 32'h1});

        @(posedge clk);
        #1;
        run8(8'h5A, 8'h33, 1'b0, {1'b1, 1'b0, 8'h8D}, "basic");
        run8(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, "wrap");
        run8(8'h7F, 8'h00, 1'b1, {1'b1, 1'b0, 8'h80}, "cin_ovf");

        // Backpressure with stray operand pulses in RUN and DONE.
        ordy8 = 1'b0;
        send(0, 32'h11, 32'h22, 1'b0, acc);
        @(posedge clk);
        #1 iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        @(posedge clk);
        #1 iv8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid8 && n < 50);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {22'd0, out_valid8, in_ready8, busy8, ovf8, cout8, sum8},
                {22'd0, 3'b100, 1'b0, 1'b0, 8'h33});
            @(posedge clk);
            #1 iv8 = (k < 2); a8 = 8'h01; b8 = 8'h01;
            @(negedge clk);
        end
        @(posedge clk);
        #1 iv8 = 1'b0; ordy8 = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 34'(out_valid8), 34'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle", {32'd0, in_ready8, out_valid8}, {32'd0, 2'b10});

        // Reset on the third RUN cycle.
        @(posedge clk);
        #1;
        send(0, 32'hAA, 32'h55, 1'b0, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_flags", {31'd0, out_valid8, busy8, in_ready8}, {31'd0, 3'b001});
        chk("abort_result", 34'({ovf8, cout8, sum8}), 34'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run8(8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30}, "after_abort");

        fork
            begin
                prev = 0;
                for (int i = 0; i < 1000; i++) begin
                    ra = $urandom;
                    rb = $urandom;
                    send(0, ra, rb, 1'($urandom_range(1)), acc);
                    if (i > 0) chk("spacing8", 34'(acc - prev), 34'd10);
                    prev = acc;
                end
            end
            begin
                int prev1, acc1;
                prev1 = 0;
                for (int i = 0; i < 1000; i++) begin
                    send(1, $urandom, $urandom, 1'($urandom_range(1)), acc1);
                    if (i > 0) chk("spacing1", 34'(acc1 - prev1), 34'd3);
                    prev1 = acc1;
                end
            end
        join
        repeat (12) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

endmodule
